multi_chan_dap: RTL and testbench
=================================

MULTI_CHAN_DAP -- requirements
Module: multi_chan_dap

Interface
REQ-001 SHALL have parameter IR_W, default 4: instruction register width, minimum 3.
REQ-002 SHALL have parameter NUM_CH, default 2: number of core debug data channels, 1..(2^IR_W-3).
REQ-003 SHALL have parameter DR_W, default 32: channel data register width, minimum 2.
REQ-004 SHALL have parameter IDCODE_VAL, default 32'h1DC0_0001: IDCODE register value, bit 0 = 1.
REQ-005 SHALL have port: tck  input  1  test clock; one clock; all state on posedge tck except the tdo register.
REQ-006 SHALL have port: trst  input  1  test reset; asynchronous, active-high.
REQ-007 SHALL have ports: tms  input  1  test mode select; tdi  input  1  test data in.
REQ-008 SHALL have port: tdo  output  1  test data out, registered.
REQ-009 SHALL have port: tdo_en  output  1  high while the TAP is in Shift-IR or Shift-DR.
REQ-010 SHALL have port: ch_cap_data  input  NUM_CH*DR_W  per-channel capture values, channel k at slice [k*DR_W +: DR_W].
REQ-011 SHALL have port: ch_upd_data  output  NUM_CH*DR_W  per-channel last-updated values, same slicing.
REQ-012 SHALL have port: ch_upd_vld  output  NUM_CH  one-tck pulse per channel on Update-DR.
REQ-013 SHALL have port: ch_sel  output  NUM_CH  one-hot, the channel addressed by the current IR; all zero otherwise.

Function
REQ-014 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing on posedge tck per tms; five tck with tms=1 reach Test-Logic-Reset from any state.
REQ-015 SHALL decode IR: 1 = IDCODE; 2+k = CH_k for k < NUM_CH; all-ones = BYPASS; every other code SHALL behave as BYPASS.
REQ-016 SHALL load IR to IDCODE in Test-Logic-Reset.
REQ-017 SHALL load the IR shift register with the pattern ...0001 (LSBs 2'b01, rest 0) in Capture-IR.
REQ-018 SHALL shift right in Shift-IR and Shift-DR: tdi enters the MSB, and the LSB drives tdo.
REQ-019 SHALL commit the IR shift register to IR in Update-IR only; IR SHALL be unchanged during a shift.
REQ-020 SHALL size the selected DR as follows: BYPASS 1 bit, cleared in Capture-DR; IDCODE 32 bits, loaded with IDCODE_VAL in Capture-DR; CH_k DR_W bits, loaded with the ch_cap_data slice in Capture-DR.
REQ-021 SHALL, in Update-DR with CH_k selected, copy the shift register to the ch_upd_data slice k and assert ch_upd_vld[k] for exactly one tck; other slices hold.
REQ-022 SHALL update tdo on negedge tck from the active shift-register LSB; outside shift states, tdo SHALL hold 0.
REQ-023 SHALL count an Exit1 to Pause to Exit2 to Shift sequence as resuming the shift with no data loss and no extra capture.
REQ-024 SHALL NOT pulse ch_upd_vld on an Update-DR reached without an intervening Capture-DR after reset; the capture SHALL always precede it per the FSM.

Reset
REQ-025 SHALL, on trst high and asynchronously: FSM to Test-Logic-Reset, IR to IDCODE, tdo 0, tdo_en 0, ch_upd_data 0, ch_upd_vld 0, ch_sel 0, shift registers 0.
REQ-026 SHALL, on trst asserted mid-shift, discard the shift contents and leave ch_upd_data unchanged from reset value 0.

Configuration
REQ-027 SHALL, with MULTI_CHAN_DAP_IDCODE_EN defined, provide IDCODE as specified.
REQ-028 SHALL, without MULTI_CHAN_DAP_IDCODE_EN, reset IR to BYPASS, decode code 1 as BYPASS, and remove the IDCODE register.

Structure
REQ-029 SHALL place the TAP state enum and the IR code constants (IDCODE, BYPASS, CH_BASE=2) in shared package dap_pkg.
REQ-030 SHALL contain exactly one sub-module, tap_fsm: the TAP state machine with tms in and state out.

Verification
REQ-031 SHALL test reset: trst pulse, then tms=0 into Shift-DR and 32 shifts -> tdo returns 32'h1DC0_0001 LSB first.
REQ-032 SHALL test IR capture: Shift-IR with IR_W=4 -> first 4 tdo bits are 1,0,0,0.
REQ-033 SHALL test a channel write: IR=2 (CH_0), shift DR 32'hDEAD_BEEF, Update-DR -> ch_upd_data[31:0]=32'hDEAD_BEEF, ch_upd_vld=2'b01 for 1 tck, ch_sel=2'b01.
REQ-034 SHALL test a channel read with Pause: IR=3, ch_cap_data[63:32]=32'h1234_5678, 16 shifts, Pause-DR for 5 tck, 16 more shifts -> tdo stream is 32'h1234_5678, and ch_upd_vld[1] pulses once.
REQ-035 SHALL test BYPASS and illegal codes: IR=4'hF or 4'h9, shift 8 bits 8'hA5 -> tdo equals tdi delayed by 1 tck.
REQ-036 SHALL test asynchronous reset: trst asserted during CH_0 Shift-DR -> immediate Test-Logic-Reset, no ch_upd_vld, IR=IDCODE.

Source files
------------

// File: rtl/dap_pkg.sv
// Shared TAP state encoding and IR code constants for the multi-channel debug access port.
package dap_pkg;

  typedef enum logic [3:0] {
    ST_EXIT2_DR = 4'h0,
    ST_EXIT1_DR = 4'h1,
    ST_SHIFT_DR = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EXIT2_IR = 4'h8,
    ST_EXIT1_IR = 4'h9,
    ST_SHIFT_IR = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_e;

  localparam int IR_CODE_IDCODE  = 1;
  localparam int IR_CODE_BYPASS  = -1;  // all ones once sized to the IR width
  localparam int IR_CODE_CH_BASE = 2;

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 16-state TAP controller; state is exposed directly for decode and observation.
module tap_fsm
  import dap_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_i,
  input  logic       tms_i,
  output tap_state_e state_o
);

  tap_state_e state_q;

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q <= ST_TLR;
    end else begin
      case (state_q)
        ST_TLR:      state_q <= tms_i ? ST_TLR      : ST_RTI;
        ST_RTI:      state_q <= tms_i ? ST_SEL_DR   : ST_RTI;
        ST_SEL_DR:   state_q <= tms_i ? ST_SEL_IR   : ST_CAP_DR;
        ST_CAP_DR:   state_q <= tms_i ? ST_EXIT1_DR : ST_SHIFT_DR;
        ST_SHIFT_DR: state_q <= tms_i ? ST_EXIT1_DR : ST_SHIFT_DR;
        ST_EXIT1_DR: state_q <= tms_i ? ST_UPD_DR   : ST_PAUSE_DR;
        ST_PAUSE_DR: state_q <= tms_i ? ST_EXIT2_DR : ST_PAUSE_DR;
        ST_EXIT2_DR: state_q <= tms_i ? ST_UPD_DR   : ST_SHIFT_DR;
        ST_UPD_DR:   state_q <= tms_i ? ST_SEL_DR   : ST_RTI;
        ST_SEL_IR:   state_q <= tms_i ? ST_TLR      : ST_CAP_IR;
        ST_CAP_IR:   state_q <= tms_i ? ST_EXIT1_IR : ST_SHIFT_IR;
        ST_SHIFT_IR: state_q <= tms_i ? ST_EXIT1_IR : ST_SHIFT_IR;
        ST_EXIT1_IR: state_q <= tms_i ? ST_UPD_IR   : ST_PAUSE_IR;
        ST_PAUSE_IR: state_q <= tms_i ? ST_EXIT2_IR : ST_PAUSE_IR;
        ST_EXIT2_IR: state_q <= tms_i ? ST_UPD_IR   : ST_SHIFT_IR;
        ST_UPD_IR:   state_q <= tms_i ? ST_SEL_DR   : ST_RTI;
        default:     state_q <= ST_TLR;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/multi_chan_dap.sv
// Multi-channel JTAG debug access port: TAP, IR decode, BYPASS/IDCODE/per-channel data registers.
// Define MULTI_CHAN_DAP_IDCODE_EN to include the IDCODE register; otherwise IR resets to BYPASS.
module multi_chan_dap
  import dap_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          NUM_CH     = 2,
  parameter int          DR_W       = 32,
  parameter logic [31:0] IDCODE_VAL = 32'h1DC0_0001
) (
  input  logic                     tck,
  input  logic                     trst,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  input  logic [NUM_CH*DR_W-1:0]   ch_cap_data,
  output logic [NUM_CH*DR_W-1:0]   ch_upd_data,
  output logic [NUM_CH-1:0]        ch_upd_vld,
  output logic [NUM_CH-1:0]        ch_sel
);

  tap_state_e             state;
  logic [IR_W-1:0]        ir_q;
  logic [IR_W-1:0]        ir_sr_q;
  logic                   byp_q;
  logic                   cap_seen_q;
  logic                   tdo_q;
  logic                   tdo_d;
  logic                   is_ch;
  logic                   is_id;
  logic                   id_lsb;
  logic [DR_W-1:0]        ch_sr_q;
  logic [DR_W-1:0]        cap_ch;
  logic [NUM_CH*DR_W-1:0] upd_data_q;
  logic [NUM_CH-1:0]      upd_vld_q;
  logic [NUM_CH-1:0]      sel;

  tap_fsm u_fsm (
    .tck_i   (tck),
    .trst_i  (trst),
    .tms_i   (tms),
    .state_o (state)
  );

`ifdef MULTI_CHAN_DAP_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RESET = IR_W'(IR_CODE_IDCODE);
  logic [31:0] id_sr_q;

  assign is_id  = (ir_q == IR_W'(IR_CODE_IDCODE));
  assign id_lsb = id_sr_q[0];

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      id_sr_q <= '0;
    end else if (state == ST_CAP_DR) begin
      id_sr_q <= IDCODE_VAL;
    end else if (state == ST_SHIFT_DR && is_id) begin
      id_sr_q <= {tdi, id_sr_q[31:1]};
    end
  end
`else
  localparam logic [IR_W-1:0] IR_RESET = IR_W'(IR_CODE_BYPASS);
  assign is_id  = 1'b0;
  assign id_lsb = 1'b0;
`endif

  // Channel codes are contiguous from CH_BASE; anything unmatched falls through to BYPASS.
  always_comb begin
    sel    = '0;
    cap_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ir_q == IR_W'(IR_CODE_CH_BASE + k)) begin
        sel[k] = 1'b1;
        cap_ch = ch_cap_data[k*DR_W +: DR_W];
      end
    end
  end

  assign is_ch = |sel;

  always_comb begin
    tdo_d = 1'b0;
    if (state == ST_SHIFT_IR) begin
      tdo_d = ir_sr_q[0];
    end else if (state == ST_SHIFT_DR) begin
      tdo_d = is_ch ? ch_sr_q[0] : (is_id ? id_lsb : byp_q);
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_q       <= IR_RESET;
      ir_sr_q    <= '0;
      byp_q      <= 1'b0;
      ch_sr_q    <= '0;
      cap_seen_q <= 1'b0;
      upd_data_q <= '0;
      upd_vld_q  <= '0;
    end else begin
      upd_vld_q <= '0;
      case (state)
        ST_TLR:      ir_q    <= IR_RESET;
        ST_CAP_IR:   ir_sr_q <= IR_W'(1);
        ST_SHIFT_IR: ir_sr_q <= {tdi, ir_sr_q[IR_W-1:1]};
        ST_UPD_IR:   ir_q    <= ir_sr_q;
        ST_CAP_DR: begin
          byp_q      <= 1'b0;
          ch_sr_q    <= cap_ch;
          cap_seen_q <= 1'b1;
        end
        ST_SHIFT_DR: begin
          if (is_ch) begin
            ch_sr_q <= {tdi, ch_sr_q[DR_W-1:1]};
          end else if (!is_id) begin
            byp_q <= tdi;
          end
        end
        ST_UPD_DR: begin
          if (cap_seen_q && is_ch) begin
            upd_vld_q <= sel;
            for (int k = 0; k < NUM_CH; k++) begin
              if (sel[k]) upd_data_q[k*DR_W +: DR_W] <= ch_sr_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // tdo launches on the falling edge so the probe samples it on the next rising edge.
  always_ff @(negedge tck or posedge trst) begin
    if (trst) tdo_q <= 1'b0;
    else      tdo_q <= tdo_d;
  end

  assign tdo         = tdo_q;
  assign tdo_en      = (state == ST_SHIFT_IR) || (state == ST_SHIFT_DR);
  assign ch_upd_data = upd_data_q;
  assign ch_upd_vld  = upd_vld_q;
  assign ch_sel      = sel;

endmodule

// File: tb/tb_multi_chan_dap.sv
// Self-checking bench for multi_chan_dap: directed vector table, corner sequences and a random scan mix.
module tb_multi_chan_dap;

  localparam int          IR_W   = 4;
  localparam int          NUM_CH = 2;
  localparam int          DR_W   = 32;
  localparam logic [31:0] IDV    = 32'h1DC0_0001;
  localparam logic [31:0] CAP0   = 32'hCAFE_0000;
  localparam logic [31:0] CAP1   = 32'h1234_5678;

`ifdef MULTI_CHAN_DAP_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RST = 4'h1;
  localparam bit              ID_EN  = 1'b1;
`else
  localparam logic [IR_W-1:0] IR_RST = 4'hF;
  localparam bit              ID_EN  = 1'b0;
`endif

  // clock / reset
  logic tck = 1'b0;
  logic trst, tms, tdi, tdo, tdo_en;
  logic [NUM_CH*DR_W-1:0] ch_cap_data, ch_upd_data;
  logic [NUM_CH-1:0]      ch_upd_vld, ch_sel;

  always #5 tck = ~tck;

  multi_chan_dap #(.IR_W(IR_W), .NUM_CH(NUM_CH), .DR_W(DR_W), .IDCODE_VAL(IDV)) dut (
    .tck         (tck),
    .trst        (trst),
    .tms         (tms),
    .tdi         (tdi),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .ch_cap_data (ch_cap_data),
    .ch_upd_data (ch_upd_data),
    .ch_upd_vld  (ch_upd_vld),
    .ch_sel      (ch_sel)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // scoreboard / reference model state
  int               checks = 0;
  int               errors = 0;
  logic [IR_W-1:0]  ir_m;
  logic [DR_W-1:0]  upd_m [NUM_CH];
  logic [0:0]       exp_q [$];
  int               vld_cnt;
  logic [NUM_CH-1:0] vld_or;
  logic             tdo_s, en_s, en_ok;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int ch_of(input logic [IR_W-1:0] ir);
    if (int'(ir) >= 2 && int'(ir) < 2 + NUM_CH) return int'(ir) - 2;
    return -1;
  endfunction

  function automatic logic [NUM_CH-1:0] sel_of(input logic [IR_W-1:0] ir);
    logic [NUM_CH-1:0] s;
    s = '0;
    if (ch_of(ir) >= 0) s[ch_of(ir)] = 1'b1;
    return s;
  endfunction

  function automatic logic [NUM_CH*DR_W-1:0] upd_cat();
    logic [NUM_CH*DR_W-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k*DR_W +: DR_W] = upd_m[k];
    return v;
  endfunction

  // Selected data register as a bit queue, LSB at the front (next bit out on tdo).
  task automatic model_capture();
    int k;
    k = ch_of(ir_m);
    exp_q.delete();
    if (k >= 0) begin
      for (int i = 0; i < DR_W; i++) exp_q.push_back(ch_cap_data[k*DR_W + i]);
    end else if (ID_EN && ir_m == 4'h1) begin
      for (int i = 0; i < 32; i++) exp_q.push_back(IDV[i]);
    end else begin
      exp_q.push_back(1'b0);
    end
  endtask

  // driver tasks: bench sits at negedge+1 between ticks
  task automatic tick(input logic tms_v, input logic tdi_v);
    tms   = tms_v;
    tdi   = tdi_v;
    tdo_s = tdo;
    en_s  = tdo_en;
    @(posedge tck);
    #1;
    if (ch_upd_vld != '0) begin
      vld_cnt++;
      vld_or |= ch_upd_vld;
    end
    @(negedge tck);
    #1;
  endtask

  task automatic scan_ir(input logic [IR_W-1:0] code, output logic [63:0] got, output logic [63:0] exp);
    logic [0:0] q [$];
    got = '0;
    exp = '0;
    q.push_back(1'b1);
    for (int i = 1; i < IR_W; i++) q.push_back(1'b0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++) begin
      exp[i] = q.pop_front();
      q.push_back(code[i]);
      tick(i == IR_W - 1, code[i]);
      got[i] = tdo_s;
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++) ir_m[i] = q[i];
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, input int pause_at, input int plen,
                         output logic [63:0] got, output logic [63:0] exp,
                         output logic [NUM_CH-1:0] exp_vld);
    int k;
    got = '0;
    exp = '0;
    exp_vld = '0;
    vld_cnt = 0;
    vld_or = '0;
    en_ok = 1'b1;
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    model_capture();
    for (int i = 0; i < n; i++) begin
      logic last, pz;
      last = (i == n - 1);
      pz = (i == pause_at - 1) && !last;
      exp[i] = exp_q.pop_front();
      exp_q.push_back(din[i]);
      tick(last | pz, din[i]);
      got[i] = tdo_s;
      en_ok &= en_s;
      if (pz) begin
        tick(1'b0, 1'b0);
        repeat (plen) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
      end
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    k = ch_of(ir_m);
    if (k >= 0) begin
      for (int j = 0; j < DR_W; j++) upd_m[k][j] = exp_q[j];
      exp_vld[k] = 1'b1;
    end
  endtask

  typedef struct {
    logic [3:0]  ir;
    logic [31:0] din;
    logic [31:0] exp_tdo;
    logic [1:0]  exp_sel;
    logic [1:0]  exp_vld;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [63:0] got, exp, din;
    logic [NUM_CH-1:0] ev;
    int n, pat;

    vecs[0] = '{4'h2, 32'hDEAD_BEEF, CAP0,          2'b01, 2'b01};
    vecs[1] = '{4'h3, 32'h0BAD_F00D, CAP1,          2'b10, 2'b10};
    vecs[2] = '{4'hF, 32'hA5A5_A5A5, 32'h4B4B_4B4A, 2'b00, 2'b00};
    vecs[3] = '{4'h9, 32'h0000_00A5, 32'h0000_014A, 2'b00, 2'b00};
    vecs[4] = '{4'h0, 32'h8000_0001, 32'h0000_0002, 2'b00, 2'b00};
`ifdef MULTI_CHAN_DAP_IDCODE_EN
    vecs[5] = '{4'h1, 32'h5555_5555, IDV,           2'b00, 2'b00};
`else
    vecs[5] = '{4'h1, 32'h5555_5555, 32'hAAAA_AAAA, 2'b00, 2'b00};
`endif

    trst = 1'b1;
    tms = 1'b1;
    tdi = 1'b0;
    ch_cap_data = {CAP1, CAP0};
    vld_cnt = 0;
    vld_or = '0;
    ir_m = IR_RST;
    for (int k = 0; k < NUM_CH; k++) upd_m[k] = '0;
    repeat (2) @(negedge tck);
    #1;

    // reset state
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_tdo_en", 64'(tdo_en), 64'd0);
    check("rst_upd_data", 64'(ch_upd_data), 64'd0);
    check("rst_upd_vld", 64'(ch_upd_vld), 64'd0);
    check("rst_sel", 64'(ch_sel), 64'd0);
    trst = 1'b0;
    tick(1'b0, 1'b0);

    // DR right after reset: IDCODE, or a 1-bit bypass when IDCODE is compiled out
    din = {32'h0, $urandom()};
    scan_dr(32, din, 0, 0, got, exp, ev);
    check("reset_dr_word", 64'(got[31:0]), ID_EN ? 64'(IDV) : 64'({din[30:0], 1'b0}));
    check("reset_dr_en", 64'(en_ok), 64'd1);

    // IR capture pattern shifts out LSB first as 1,0,0,0
    scan_ir(4'h2, got, exp);
    check("ir_capture", got, 64'h1);
    check("ir_ch0_sel", 64'(ch_sel), 64'h1);

    // vector table
    for (int v = 0; v < 6; v++) begin
      scan_ir(vecs[v].ir, got, exp);
      check("vec_sel", 64'(ch_sel), 64'(vecs[v].exp_sel));
      scan_dr(32, 64'(vecs[v].din), 0, 0, got, exp, ev);
      check("vec_tdo", 64'(got[31:0]), 64'(vecs[v].exp_tdo));
      check("vec_vld", 64'(vld_or), 64'(vecs[v].exp_vld));
      check("vec_vld_cnt", 64'(vld_cnt), (vecs[v].exp_vld != 2'b00) ? 64'd1 : 64'd0);
      if (vecs[v].exp_vld[0]) check("vec_upd0", 64'(ch_upd_data[31:0]), 64'(vecs[v].din));
      if (vecs[v].exp_vld[1]) check("vec_upd1", 64'(ch_upd_data[63:32]), 64'(vecs[v].din));
    end

    // channel read through Pause-DR halfway
    ch_cap_data = {CAP1, 32'h0F0F_0F0F};
    scan_ir(4'h3, got, exp);
    din = {32'h0, $urandom()};
    scan_dr(32, din, 16, 5, got, exp, ev);
    check("pause_tdo", 64'(got[31:0]), 64'(CAP1));
    check("pause_vld_cnt", 64'(vld_cnt), 64'd1);
    check("pause_vld", 64'(vld_or), 64'h2);
    check("pause_upd1", 64'(ch_upd_data[63:32]), 64'(din[31:0]));

    // trst mid-shift on CH_0
    scan_ir(4'h2, got, exp);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'($urandom_range(0, 1)));
    vld_cnt = 0;
    vld_or = '0;
    #2 trst = 1'b1;
    #1;
    check("arst_tdo", 64'(tdo), 64'd0);
    check("arst_tdo_en", 64'(tdo_en), 64'd0);
    check("arst_sel", 64'(ch_sel), 64'd0);
    check("arst_upd_data", 64'(ch_upd_data), 64'd0);
    check("arst_vld", 64'(ch_upd_vld), 64'd0);
    @(negedge tck);
    #1;
    repeat (3) tick(1'b1, 1'b0);
    trst = 1'b0;
    ir_m = IR_RST;
    for (int k = 0; k < NUM_CH; k++) upd_m[k] = '0;
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    check("arst_no_vld", 64'(vld_cnt), 64'd0);
    din = {32'h0, $urandom()};
    scan_dr(32, din, 0, 0, got, exp, ev);
    check("arst_ir_dr", 64'(got[31:0]), ID_EN ? 64'(IDV) : 64'({din[30:0], 1'b0}));
    check("arst_upd_kept", 64'(ch_upd_data), 64'd0);

    // random scans against the queue model
    for (int it = 0; it < 40; it++) begin
      ch_cap_data = {$urandom(), $urandom()};
      if ($urandom_range(0, 2) == 0) begin
        scan_ir(4'($urandom_range(0, 15)), got, exp);
        check("rnd_ir_tdo", got, exp);
        check("rnd_ir_sel", 64'(ch_sel), 64'(sel_of(ir_m)));
      end else begin
        n = $urandom_range(1, 64);
        pat = $urandom_range(0, n);
        din = {$urandom(), $urandom()};
        scan_dr(n, din, pat, $urandom_range(0, 4), got, exp, ev);
        check("rnd_dr_tdo", got, exp);
        check("rnd_dr_en", 64'(en_ok), 64'd1);
        check("rnd_upd_data", 64'(ch_upd_data), 64'(upd_cat()));
        check("rnd_vld", 64'(vld_or), 64'(ev));
        check("rnd_vld_cnt", 64'(vld_cnt), (ev != '0) ? 64'd1 : 64'd0);
        check("rnd_idle_en", 64'(tdo_en), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
